adc_conversion_scheduler: RTL and testbench
===========================================

// Module: adc_conversion_scheduler
// PURPOSE
//  Round-robin scheduler sharing one SAR ADC (adc_top) among NUM_REQ requesters. Latches the
//  granted requester's config words, pulses start_conversion, waits for the synchronised
//  conversion_finished, captures result_out and returns it on a single response channel with
//  requester ID. Sits between system logic and adc_top; clk is the system clock, not the
//  self-timed ADC loop clock.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8)
//  START_CYCLES   4     start pulse width in clk cycles (>=1); must exceed edge-detect window
//  TIMEOUT_CYCLES 4096  max cycles spent in WAIT_CLR+WAIT_DONE before abort
//  SYNC_STAGES    2     synchroniser depth for conversion_finished (>=2)
// PORTS
//  clk               in   1          system clock
//  rst_n             in   1          reset, asynchronous, active-low
//  req_valid         in   NUM_REQ    per-requester conversion request
//  req_ready         out  NUM_REQ    one-hot 1-cycle grant; request consumed when valid&ready
//  req_config_1      in   16*NUM_REQ config_1 per requester, slice i = [16i+15:16i]
//  req_config_2      in   16*NUM_REQ config_2 per requester
//  rsp_valid         out  1          response available
//  rsp_ready         in   1          response accepted
//  rsp_id            out  $clog2(NUM_REQ) index of requester the response belongs to
//  rsp_data          out  16         captured result (0 on timeout)
//  rsp_err           out  1          1 = conversion timed out
//  adc_start_out     out  1          to adc_top start_conversion_in
//  adc_config_1_out  out  16         to adc_top config_1_in
//  adc_config_2_out  out  16         to adc_top config_2_in
//  adc_result_in     in   16         from adc_top result_out (stable while finished high)
//  adc_finished_in   in   1          from adc_top conversion_finished_out (async to clk)
//  busy              out  1          high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=0, synchroniser flops=0, timeout counter=0.
//  Reset is async mid-conversion: start deasserts immediately; in-flight request is dropped.
//  FSM: IDLE -> SETUP -> START -> WAIT_CLR -> WAIT_DONE -> RESP -> IDLE.
//  IDLE: if any req_valid, grant lowest index at or after rr pointer (wrapping); assert
//   req_ready[g] this cycle only; latch configs and g; rr pointer <= (g+1) mod NUM_REQ.
//   No req_valid -> stay, req_ready=0.
//  SETUP: 1 cycle; adc_config_*_out already drive latched values (settle before start).
//  START: adc_start_out=1 for exactly START_CYCLES cycles, then WAIT_CLR.
//  adc_config_*_out held constant from SETUP through RESP exit; change only on next grant.
//  fin_s = adc_finished_in after SYNC_STAGES flops.
//  WAIT_CLR: wait for fin_s=0 (core acknowledges new conversion) -> WAIT_DONE.
//  WAIT_DONE: on fin_s=1, capture adc_result_in into rsp_data, rsp_err=0 -> RESP.
//  Timeout counter clears on START exit, counts in WAIT_CLR/WAIT_DONE; reaching
//   TIMEOUT_CYCLES-1 -> RESP with rsp_err=1, rsp_data=0 (timeout wins over same-cycle fin_s).
//  RESP: rsp_valid=1, rsp_id/data/err stable until rsp_valid&rsp_ready, then IDLE;
//   rsp_valid drops next cycle. Minimum grant-to-grant spacing: START_CYCLES+5 cycles
//   plus the ADC conversion time.
//  Requester deasserting req_valid without grant: allowed, no effect. Requests are not
//   accepted outside IDLE (req_ready=0).
//  NUM_REQ=1 degenerates to a single-client sequencer; rsp_id width forced to >=1.
// TESTING
//  1 Single req0, config_1=16'h0A05, config_2=16'h8421; model finishes after 40 clk
//   with result 16'h1234 -> start high 4 cycles, configs stable throughout,
//   rsp_valid with id=0, data=16'h1234, err=0.
//  2 req0..req3 all valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0;
//   rsp_id matches; adc_config_* switches only at each grant.
//  3 Model never drops finished (stuck high) -> timeout after 4096 wait cycles:
//   rsp_err=1, rsp_data=0, FSM back to IDLE, next request serviced normally.
//  4 rsp_ready held low 20 cycles in RESP -> rsp_* stable, no new req_ready, start stays 0.
//  5 rst_n asserted during WAIT_DONE -> adc_start_out, busy, rsp_valid=0 same cycle;
//   after release, a fresh req2 is granted first (rr pointer=0, lowest valid=2).
//  6 finished pulses at clk-asynchronous random phases over 1000 conversions -> every
//   result captured matches model, no duplicate or lost responses.

Source files
------------

// File: rtl/adc_conversion_scheduler.sv
// Round-robin scheduler sharing one SAR ADC core among NUM_REQ requesters; each granted
// request is converted and its result (or a timeout error) returned with the requester ID.
`timescale 1ns/1ps
module adc_conversion_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SYNC_STAGES    = 2,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_config_1,
    input  logic [16*NUM_REQ-1:0]   req_config_2,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [15:0]             rsp_data,
    output logic                    rsp_err,
    output logic                    adc_start_out,
    output logic [15:0]             adc_config_1_out,
    output logic [15:0]             adc_config_2_out,
    input  logic [15:0]             adc_result_in,
    input  logic                    adc_finished_in,
    output logic                    busy
);

    localparam int AW  = IDW + 1;
    localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] START_LAST = SCW'(START_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] ID_LAST    = IDW'(NUM_REQ - 1);
    localparam logic [AW-1:0]  NUM_REQ_A  = AW'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_START     = 3'd2,
        S_WAIT_CLR  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [IDW-1:0]         rr_q, rr_d;
    logic [IDW-1:0]         id_q, id_d;
    logic [15:0]            cfg1_q, cfg1_d;
    logic [15:0]            cfg2_q, cfg2_d;
    logic [15:0]            data_q, data_d;
    logic                   err_q, err_d;
    logic [SCW-1:0]         scnt_q, scnt_d;
    logic [TCW-1:0]         tcnt_q, tcnt_d;
    logic                   start_q, busy_q, rsp_valid_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   fin_s;
    logic                   gnt_found_s;
    logic [IDW-1:0]         gnt_idx_s;
    logic [AW-1:0]          arb_sum_s;
    logic [AW-1:0]          arb_idx_s;
    logic [15:0]            cfg1_arr_s [NUM_REQ];
    logic [15:0]            cfg2_arr_s [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign cfg1_arr_s[gi] = req_config_1[16*gi +: 16];
        assign cfg2_arr_s[gi] = req_config_2[16*gi +: 16];
    end

    assign fin_s = sync_q[SYNC_STAGES-1];

    // Round-robin pick: first valid requester at or after rr_q, wrapping
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        arb_sum_s   = '0;
        arb_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum_s = {1'b0, rr_q} + AW'(k);
            arb_idx_s = (arb_sum_s >= NUM_REQ_A) ? (arb_sum_s - NUM_REQ_A) : arb_sum_s;
            if (!gnt_found_s && req_valid[arb_idx_s[IDW-1:0]]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = arb_idx_s[IDW-1:0];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Grant is a same-cycle acknowledge, only offered while idle
    always_comb begin
        req_ready = '0;
        if ((state_q == S_IDLE) && gnt_found_s) begin
            req_ready[gnt_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Sequencer next-state and datapath updates
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        cfg1_d  = cfg1_q;
        cfg2_d  = cfg2_q;
        data_d  = data_q;
        err_d   = err_q;
        scnt_d  = scnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found_s) begin
                    state_d = S_SETUP;
                    id_d    = gnt_idx_s;
                    cfg1_d  = cfg1_arr_s[gnt_idx_s];
                    cfg2_d  = cfg2_arr_s[gnt_idx_s];
                    rr_d    = (gnt_idx_s == ID_LAST) ? '0 : (gnt_idx_s + IDW'(1));
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                state_d = S_START;
                scnt_d  = '0;
            end
            S_START: begin
                if (scnt_q == START_LAST) begin
                    state_d = S_WAIT_CLR;
                    tcnt_d  = '0;
                end else begin
                    scnt_d  = scnt_q + SCW'(1);
                end
            end
            // Timeout is checked first so it wins over a same-cycle finish
            S_WAIT_CLR: begin
                if (tcnt_q == TMO_LAST) begin
                    state_d = S_RESP;
                    data_d  = 16'h0000;
                    err_d   = 1'b1;
                end else if (!fin_s) begin
                    state_d = S_WAIT_DONE;
                    tcnt_d  = tcnt_q + TCW'(1);
                end else begin
                    tcnt_d  = tcnt_q + TCW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tcnt_q == TMO_LAST) begin
                    state_d = S_RESP;
                    data_d  = 16'h0000;
                    err_d   = 1'b1;
                end else if (fin_s) begin
                    state_d = S_RESP;
                    data_d  = adc_result_in;
                    err_d   = 1'b0;
                end else begin
                    tcnt_d  = tcnt_q + TCW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            cfg1_q      <= 16'h0000;
            cfg2_q      <= 16'h0000;
            data_q      <= 16'h0000;
            err_q       <= 1'b0;
            scnt_q      <= '0;
            tcnt_q      <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            cfg1_q      <= cfg1_d;
            cfg2_q      <= cfg2_d;
            data_q      <= data_d;
            err_q       <= err_d;
            scnt_q      <= scnt_d;
            tcnt_q      <= tcnt_d;
            start_q     <= (state_d == S_START);
            busy_q      <= (state_d != S_IDLE);
            rsp_valid_q <= (state_d == S_RESP);
            sync_q      <= {sync_q[SYNC_STAGES-2:0], adc_finished_in};
        end
    end

    assign adc_start_out    = start_q;
    assign busy             = busy_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = id_q;
    assign rsp_data         = data_q;
    assign rsp_err          = err_q;
    assign adc_config_1_out = cfg1_q;
    assign adc_config_2_out = cfg2_q;

endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Directed bench for adc_conversion_scheduler with a behavioural ADC core whose result is
// cfg1 ^ cfg2 ^ salt, so every expected response is computed from bench-side constants.
`timescale 1ns/1ps
module tb_adc_conversion_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_config_1;
    logic [63:0] req_config_2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        adc_start_out;
    logic [15:0] adc_config_1_out;
    logic [15:0] adc_config_2_out;
    logic [15:0] adc_result_in;
    logic        adc_finished_in;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bit          model_stuck = 1'b0;
    int          model_conv  = 8;
    real         model_phase = 4.0;
    logic [15:0] model_salt  = 16'h0000;

    always #5 clk = ~clk;

    adc_conversion_scheduler #(
        .NUM_REQ(4), .START_CYCLES(4), .TIMEOUT_CYCLES(4096), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_config_1(req_config_1), .req_config_2(req_config_2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .adc_start_out(adc_start_out),
        .adc_config_1_out(adc_config_1_out), .adc_config_2_out(adc_config_2_out),
        .adc_result_in(adc_result_in), .adc_finished_in(adc_finished_in),
        .busy(busy)
    );

    // ADC core model: drops finished on start, raises it at an arbitrary phase later
    initial begin
        adc_finished_in = 1'b0;
        adc_result_in   = 16'h0000;
        forever begin
            @(posedge adc_start_out);
            if (!model_stuck) begin
                #3;
                adc_finished_in = 1'b0;
                repeat (model_conv) @(posedge clk);
                #(model_phase);
                adc_result_in   = adc_config_1_out ^ adc_config_2_out ^ model_salt;
                adc_finished_in = 1'b1;
            end
        end
    end

    task automatic wait_grant(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            #1;
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        req_valid    = 4'b0000;
        rsp_ready    = 1'b0;
        req_config_1 = 64'hA5A5_0F0F_4444_1111;
        req_config_2 = 64'h5A5A_00F0_0808_2222;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, adc_start_out, rsp_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000000", {req_ready, rsp_valid, busy, adc_start_out, rsp_err});
        end
        checks++;
        if ({adc_config_1_out, adc_config_2_out, rsp_data, rsp_id} !== 50'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h %h exp 0", adc_config_1_out, adc_config_2_out, rsp_data, rsp_id);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int start_hi = 0;
        int cfg_bad  = 0;
        int n        = 0;
        model_conv  = 40;
        model_salt  = 16'h9C10;
        model_phase = 4.0;
        req_config_1[15:0] = 16'h0A05;
        req_config_2[15:0] = 16'h8421;
        @(negedge clk);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL t1_grant got %b exp 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (adc_config_1_out !== 16'h0A05 || adc_config_2_out !== 16'h8421 || adc_start_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_setup got cfg %h %h start %b busy %b exp 0a05 8421 0 1", adc_config_1_out, adc_config_2_out, adc_start_out, busy);
        end
        while (rsp_valid !== 1'b1 && n < 300) begin
            if (adc_start_out === 1'b1) start_hi++;
            if (adc_config_1_out !== 16'h0A05 || adc_config_2_out !== 16'h8421) cfg_bad++;
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL t1_rsp_timeout got rsp_valid %b exp 1", rsp_valid);
        end
        checks++;
        if (start_hi != 4) begin
            errors++;
            $display("FAIL t1_start_width got %0d exp 4", start_hi);
        end
        checks++;
        if (cfg_bad != 0) begin
            errors++;
            $display("FAIL t1_cfg_stable got %0d bad cycles exp 0", cfg_bad);
        end
        checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 16'h1234 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL t1_rsp got id %0d data %h err %b exp 0 1234 0", rsp_id, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_release got rsp_valid %b busy %b exp 0 0", rsp_valid, busy);
        end
        model_salt = 16'h0000;
    endtask

    task automatic test_round_robin;
        int          exp_id [5]   = '{0, 1, 2, 3, 0};
        logic [15:0] exp_c1 [4]   = '{16'h1111, 16'h4444, 16'h0F0F, 16'hA5A5};
        logic [15:0] exp_dat [4]  = '{16'h3333, 16'h4C4C, 16'h0FFF, 16'hFFFF};
        bit ok;
        int n;
        int bad;
        apply_reset();
        req_config_1 = 64'hA5A5_0F0F_4444_1111;
        req_config_2 = 64'h5A5A_00F0_0808_2222;
        model_conv   = 8;
        model_salt   = 16'h0000;
        req_valid    = 4'b1111;
        rsp_ready    = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(50, ok);
            checks++;
            if (!ok || req_ready !== (4'b0001 << exp_id[g])) begin
                errors++;
                $display("FAIL t2_grant%0d got %b exp %b", g, req_ready, 4'b0001 << exp_id[g]);
            end
            @(negedge clk);
            #1;
            n   = 0;
            bad = 0;
            while (rsp_valid !== 1'b1 && n < 200) begin
                if (adc_config_1_out !== exp_c1[exp_id[g]]) bad++;
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (rsp_valid !== 1'b1 || bad != 0 || adc_config_1_out !== exp_c1[exp_id[g]]) begin
                errors++;
                $display("FAIL t2_cfg%0d got valid %b bad %0d cfg %h exp 1 0 %h", g, rsp_valid, bad, adc_config_1_out, exp_c1[exp_id[g]]);
            end
            checks++;
            if (rsp_id !== 2'(exp_id[g]) || rsp_data !== exp_dat[exp_id[g]] || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL t2_rsp%0d got id %0d data %h err %b exp %0d %h 0", g, rsp_id, rsp_data, rsp_err, exp_id[g], exp_dat[exp_id[g]]);
            end
            @(negedge clk);
            if (g == 4) req_valid = 4'b0000;
        end
        rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit ok;
        bit seen_start = 1'b0;
        int waits      = 0;
        int n          = 0;
        model_stuck = 1'b1;
        req_valid   = 4'b0010;
        wait_grant(20, ok);
        checks++;
        if (!ok || req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL t3_grant got %b exp 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        while (rsp_valid !== 1'b1 && n < 5000) begin
            if (adc_start_out === 1'b1) seen_start = 1'b1;
            else if (seen_start && busy === 1'b1) waits++;
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || waits != 4096) begin
            errors++;
            $display("FAIL t3_wait_cycles got valid %b waits %0d exp 1 4096", rsp_valid, waits);
        end
        checks++;
        if (rsp_id !== 2'd1 || rsp_data !== 16'h0000 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL t3_rsp got id %0d data %h err %b exp 1 0000 1", rsp_id, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready   = 1'b0;
        model_stuck = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL t3_idle got busy %b rsp_valid %b exp 0 0", busy, rsp_valid);
        end
        req_valid = 4'b0100;
        wait_grant(20, ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL t3_next_grant got %b exp 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(200, ok);
        checks++;
        if (!ok || rsp_id !== 2'd2 || rsp_data !== 16'h0FFF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL t3_next_rsp got id %0d data %h err %b exp 2 0fff 0", rsp_id, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit ok;
        req_valid = 4'b1000;
        wait_grant(20, ok);
        checks++;
        if (!ok || req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL t4_grant got %b exp 1000", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL t4_rsp_timeout got rsp_valid %b exp 1", rsp_valid);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 16'hFFFF || rsp_err !== 1'b0 ||
                req_ready !== 4'b0000 || adc_start_out !== 1'b0) begin
                errors++;
                $display("FAIL t4_hold%0d got v %b id %0d d %h e %b rdy %b st %b exp 1 3 ffff 0 0000 0",
                         c, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, adc_start_out);
            end
        end
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL t4_release got rsp_valid %b req_ready %b exp 0 0000", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_midconv;
        bit ok;
        model_conv = 40;
        @(negedge clk);
        req_valid = 4'b0100;
        wait_grant(20, ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL t5_grant got %b exp 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || adc_start_out !== 1'b0) begin
            errors++;
            $display("FAIL t5_waiting got busy %b rsp_valid %b start %b exp 1 0 0", busy, rsp_valid, adc_start_out);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (adc_start_out !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL t5_async_reset got start %b busy %b rsp_valid %b exp 0 0 0", adc_start_out, busy, rsp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        req_valid = 4'b1100;
        wait_grant(20, ok);
        checks++;
        if (!ok || req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL t5_rr_after_reset got %b exp 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        wait_rsp(200, ok);
        checks++;
        if (!ok || rsp_id !== 2'd2 || rsp_data !== 16'h0FFF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_rsp got id %0d data %h err %b exp 2 0fff 0", rsp_id, rsp_data, rsp_err);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_random_phase;
        bit          ok;
        int          id;
        int          hold;
        int          resp_cnt = 0;
        logic [15:0] c1, c2, exp_d;
        for (int it = 0; it < 1000; it++) begin
            @(negedge clk);
            id          = $urandom_range(0, 3);
            c1          = 16'($urandom);
            c2          = 16'($urandom);
            model_salt  = 16'(it);
            model_conv  = $urandom_range(6, 15);
            model_phase = $urandom_range(1, 99) / 10.0;
            exp_d       = c1 ^ c2 ^ 16'(it);
            req_config_1[16*id +: 16] = c1;
            req_config_2[16*id +: 16] = c2;
            req_valid = 4'b0001 << id;
            wait_grant(20, ok);
            checks++;
            if (!ok || req_ready !== (4'b0001 << id)) begin
                errors++;
                $display("FAIL t6_grant%0d got %b exp %b", it, req_ready, 4'b0001 << id);
            end
            @(negedge clk);
            req_valid = 4'b0000;
            wait_rsp(100, ok);
            checks++;
            if (!ok || rsp_id !== 2'(id) || rsp_data !== exp_d || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL t6_rsp%0d got v %b id %0d data %h err %b exp 1 %0d %h 0", it, rsp_valid, rsp_id, rsp_data, rsp_err, id, exp_d);
            end
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(negedge clk);
                #1;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d) begin
                    errors++;
                    $display("FAIL t6_hold%0d got v %b data %h exp 1 %h", it, rsp_valid, rsp_data, exp_d);
                end
            end
            @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL t6_dup%0d got rsp_valid %b exp 0", it, rsp_valid);
            end else begin
                resp_cnt++;
            end
        end
        checks++;
        if (resp_cnt != 1000) begin
            errors++;
            $display("FAIL t6_count got %0d exp 1000", resp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_backpressure();
        test_reset_midconv();
        test_random_phase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
